pc_next_ctrl: RTL and testbench

//   Writer side of the program-counter register (PCm): computes pc_in and drives PC_write.

---
 rtl/pc_next_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pc_next_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_ctrl.sv
// ---------------------------------------------------------------------------
// pc_next_ctrl
//   Writer side of the program-counter register (PCm). Each cycle it picks the
//   next PC from one of three sources:
//     - sequential fetch (pc_out + 4)
//     - a branch or jump redirect (word-aligned target)
//     - hold (load-use stall, instruction memory not ready, boot window)
//   It also drives the IF/ID write enable and flush so that fetch and decode
//   stay consistent. pc_in_o is combinational from registered state plus the
//   current inputs, so PCm captures it on the same edge and no latency is added.
//
// Ports
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   pc_out_i         current PC from PCm
//   imem_ready_i     instruction memory accepts a fetch this cycle
//   stall_req_i      load-use hazard from the hazard unit
//   branch_taken_i   EX-stage branch resolved taken
//   branch_target_i  EX-stage branch target
//   jump_i           ID-stage jump
//   jump_target_i    ID-stage jump target
//   pc_in_o          next PC to PCm
//   PC_write_o       PCm load enable
//   if_id_write_o    IF/ID register write enable
//   if_id_flush_o    IF/ID bubble insert
//   misalign_o       registered; previous-cycle redirect target had [1:0] != 0
//   stall_cnt_o      saturating count of RUN/HOLD cycles with PC_write_o = 0
// ---------------------------------------------------------------------------
module pc_next_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      pc_out_i,
    input  logic             imem_ready_i,
    input  logic             stall_req_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      pc_in_o,
    output logic             PC_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned BW = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [BW-1:0]    boot_cnt_q,  boot_cnt_d;
    logic [31:0]      pend_pc_q,   pend_pc_d;
    logic             misalign_q,  misalign_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        redirect;
    logic [31:0] tgt_raw;
    logic [31:0] tgt_aln;
    logic [31:0] pc_in;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        active;

    always_comb begin
        // Branch resolves in EX, so it belongs to an older instruction than an
        // ID-stage jump and wins when both fire together.
        redirect = branch_taken_i | jump_i;
        tgt_raw  = branch_taken_i ? branch_target_i : jump_target_i;
        tgt_aln  = {tgt_raw[31:2], 2'b00};
        active   = (state_q == ST_RUN) || (state_q == ST_HOLD);

        pc_in       = RESET_VECTOR;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_pc_d   = pend_pc_q;

        case (state_q)
            ST_BOOT: begin
                // Redirect and stall inputs are ignored while booting.
                if (boot_cnt_q <= BW'(1)) begin
                    boot_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - BW'(1);
                end
            end

            ST_RUN: begin
                if (redirect) begin
                    // Redirect beats a stall: the stalled instruction is on the
                    // wrong path and is being flushed anyway.
                    pc_in       = tgt_aln;
                    pc_write    = imem_ready_i;
                    if_id_write = 1'b0;
                    if_id_flush = 1'b1;
                    if (!imem_ready_i) begin
                        pend_pc_d = tgt_aln;
                        state_d   = ST_HOLD;
                    end
                end else if (stall_req_i) begin
                    pc_in       = pc_out_i;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if_id_flush = 1'b0;
                end else begin
                    pc_in       = pc_out_i + 32'd4;
                    pc_write    = imem_ready_i;
                    if_id_write = imem_ready_i;
                    if_id_flush = 1'b0;
                end
            end

            ST_HOLD: begin
                // A redirect pending memory readiness; a newer redirect replaces
                // it, and stall_req is irrelevant because IF/ID is bubbling.
                pc_in       = redirect ? tgt_aln : pend_pc_q;
                pc_write    = imem_ready_i;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                if (redirect) begin
                    pend_pc_d = tgt_aln;
                end
                if (imem_ready_i) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d    = ST_BOOT;
                boot_cnt_d = BW'(BOOT_CYCLES);
            end
        endcase

        misalign_d = active && redirect && (tgt_raw[1:0] != 2'b00);

        stall_cnt_d = stall_cnt_q;
        if (active && !pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BW'(BOOT_CYCLES);
            pend_pc_q   <= RESET_VECTOR;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pend_pc_q   <= pend_pc_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_in_o       = pc_in;
    assign PC_write_o    = pc_write;
    assign if_id_write_o = if_id_write;
    assign if_id_flush_o = if_id_flush;
    assign misalign_o    = misalign_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
module tb_pc_next_ctrl;

    localparam logic [31:0] RV      = 32'h0000_1000;
    localparam int          BOOT    = 2;
    localparam int          CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic [31:0]   pc_out_i = '0;
    logic          imem_ready_i = 1'b0;
    logic          stall_req_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic [31:0]   branch_target_i = '0;
    logic          jump_i = 1'b0;
    logic [31:0]   jump_target_i = '0;
    logic [31:0]   pc_in_o;
    logic          PC_write_o;
    logic          if_id_write_o;
    logic          if_id_flush_o;
    logic          misalign_o;
    logic [CW-1:0] stall_cnt_o;

    pc_next_ctrl #(
        .RESET_VECTOR (RV),
        .BOOT_CYCLES  (BOOT),
        .CNT_W        (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pc_out_i        (pc_out_i),
        .imem_ready_i    (imem_ready_i),
        .stall_req_i     (stall_req_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .pc_in_o         (pc_in_o),
        .PC_write_o      (PC_write_o),
        .if_id_write_o   (if_id_write_o),
        .if_id_flush_o   (if_id_flush_o),
        .misalign_o      (misalign_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc_in;
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic        mis;
        int          cnt;
    } exp_t;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        bt;
        logic [31:0] btgt;
        logic        j;
        logic [31:0] jtgt;
        logic [31:0] pcout;
        exp_t        e;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: remaining boot cycles, an optional pending redirect
    // address, the misalign flag seen next cycle and the stall counter.
    int          m_boot;
    bit          m_hold;
    logic [31:0] m_pend;
    bit          m_mis;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".pc_in"},  pc_in_o, e.pc_in);
        chk({tag, ".pcw"},    {31'b0, PC_write_o},    {31'b0, e.pcw});
        chk({tag, ".ifw"},    {31'b0, if_id_write_o}, {31'b0, e.ifw});
        chk({tag, ".flush"},  {31'b0, if_id_flush_o}, {31'b0, e.fl});
        chk({tag, ".mis"},    {31'b0, misalign_o},    {31'b0, e.mis});
        chk({tag, ".cnt"},    32'(stall_cnt_o),       32'(e.cnt));
    endtask

    function automatic vec_t mk(input logic ready, input logic stall, input logic bt,
                                input logic [31:0] btgt, input logic j, input logic [31:0] jtgt,
                                input logic [31:0] pcout, input logic [31:0] pc_in,
                                input logic pcw, input logic ifw, input logic fl,
                                input logic mis, input int cnt);
        vec_t v;
        v.ready = ready; v.stall = stall; v.bt = bt; v.btgt = btgt;
        v.j = j; v.jtgt = jtgt; v.pcout = pcout;
        v.e.pc_in = pc_in; v.e.pcw = pcw; v.e.ifw = ifw; v.e.fl = fl;
        v.e.mis = mis; v.e.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic ready, input logic stall, input logic bt,
                         input logic [31:0] btgt, input logic j, input logic [31:0] jtgt,
                         input logic [31:0] pcout);
        imem_ready_i = ready; stall_req_i = stall; branch_taken_i = bt;
        branch_target_i = btgt; jump_i = j; jump_target_i = jtgt; pc_out_i = pcout;
    endtask

    function automatic exp_t exp_of(input logic [31:0] pc_in, input logic pcw, input logic ifw,
                                    input logic fl, input logic mis, input int cnt);
        exp_t e;
        e.pc_in = pc_in; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.mis = mis; e.cnt = cnt;
        return e;
    endfunction

    task automatic model_reset();
        m_boot = BOOT; m_hold = 0; m_pend = RV; m_mis = 0; m_cnt = 0;
    endtask

    function automatic exp_t model_eval();
        exp_t        e;
        logic [31:0] t;
        bit          r;
        r = branch_taken_i || jump_i;
        t = (branch_taken_i ? branch_target_i : jump_target_i) & 32'hFFFF_FFFC;
        e.mis = m_mis;
        e.cnt = m_cnt;
        if (m_boot > 0) begin
            e.pc_in = RV; e.pcw = 0; e.ifw = 0; e.fl = 1;
        end else if (m_hold || r) begin
            e.pc_in = r ? t : m_pend; e.pcw = imem_ready_i; e.ifw = 0; e.fl = 1;
        end else if (stall_req_i) begin
            e.pc_in = pc_out_i; e.pcw = 0; e.ifw = 0; e.fl = 0;
        end else begin
            e.pc_in = pc_out_i + 32'd4; e.pcw = imem_ready_i; e.ifw = imem_ready_i; e.fl = 0;
        end
        return e;
    endfunction

    task automatic model_step(input exp_t e);
        logic [31:0] raw;
        bit          r;
        if (m_boot > 0) begin
            m_boot--;
            return;
        end
        r   = branch_taken_i || jump_i;
        raw = branch_taken_i ? branch_target_i : jump_target_i;
        m_mis = r && (raw[1:0] != 2'b00);
        if (!e.pcw && m_cnt < CNT_MAX) m_cnt++;
        if (m_hold || r) begin
            if (r) m_pend = raw & 32'hFFFF_FFFC;
            m_hold = !imem_ready_i;
        end
    endtask

    // Assert reset mid-cycle, check the asynchronous reset outputs, release
    // one cycle later just after a rising edge.
    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        #2;
        chk_out(tag, exp_of(RV, 0, 0, 1, 0, 0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    vec_t tbl[$];
    exp_t e;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h0,         RV,           0,0,1,0,0));
        tbl.push_back(mk(1,0,1,32'h44,   0,0,        32'h0,         RV,           0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h0,         32'h4,        1,1,0,0,0));
        tbl.push_back(mk(0,0,1,32'd200,  0,0,        32'h4,         32'd200,      0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,        0,0,        32'h4,         32'd200,      0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,        0,0,        32'h4,         32'd200,      0,0,1,0,2));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h4,         32'd200,      1,0,1,0,3));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'd200,       32'd204,      1,1,0,0,3));
        tbl.push_back(mk(1,1,0,0,        0,0,        32'd100,       32'd100,      0,0,0,0,3));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'd100,       32'd104,      1,1,0,0,4));
        tbl.push_back(mk(1,1,1,32'h40,   1,32'h80,   32'd104,       32'h40,       1,0,1,0,4));
        tbl.push_back(mk(1,0,0,0,        1,32'h103,  32'h40,        32'h100,      1,0,1,0,4));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h100,       32'h104,      1,1,0,1,4));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h104,       32'h108,      1,1,0,0,4));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'hFFFF_FFFC, 32'h0,        1,1,0,0,4));
        tbl.push_back(mk(0,0,0,0,        0,0,        32'h8,         32'hC,        0,0,0,0,4));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h8,         32'hC,        1,1,0,0,5));
        tbl.push_back(mk(1,0,0,0,        1,32'h7F,   32'hC,         32'h7C,       1,0,1,0,5));
        tbl.push_back(mk(0,0,1,32'h202,  0,0,        32'h7C,        32'h200,      0,0,1,1,5));
        tbl.push_back(mk(0,0,0,0,        1,32'h300,  32'h7C,        32'h300,      0,0,1,1,6));
        tbl.push_back(mk(1,1,0,0,        0,0,        32'h7C,        32'h300,      1,0,1,0,7));
        tbl.push_back(mk(1,0,0,0,        0,0,        32'h300,       32'h304,      1,1,0,0,7));

        #1;
        do_reset("rst0");

        // Directed table, starting in the first boot cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ready, tbl[i].stall, tbl[i].bt, tbl[i].btgt,
                  tbl[i].j, tbl[i].jtgt, tbl[i].pcout);
            #3;
            chk_out($sformatf("vec%0d", i), tbl[i].e);
            next_cycle();
        end

        // Reset while a redirect is pending in HOLD: the pending target is lost.
        drive(1,0,0,0,0,0,32'h0);
        do_reset("rst1");
        for (int i = 0; i < BOOT; i++) begin
            #3; chk_out($sformatf("hb%0d", i), exp_of(RV, 0, 0, 1, 0, 0));
            next_cycle();
        end
        drive(0,0,1,32'h500,0,0,32'h10);
        #3; chk_out("hold0", exp_of(32'h500, 0, 0, 1, 0, 0));
        next_cycle();
        drive(0,0,0,0,0,0,32'h10);
        #3; chk_out("hold1", exp_of(32'h500, 0, 0, 1, 0, 1));
        do_reset("rsth");
        for (int i = 0; i < BOOT; i++) begin
            drive(1,0,0,0,0,0,32'h20);
            #3; chk_out($sformatf("hbb%0d", i), exp_of(RV, 0, 0, 1, 0, 0));
            next_cycle();
        end
        drive(1,0,0,0,0,0,32'h20);
        #3; chk_out("after", exp_of(32'h24, 1, 1, 0, 0, 0));
        next_cycle();

        // Stall counter saturation.
        do_reset("rst2");
        drive(0,0,0,0,0,0,32'h40);
        for (int i = 0; i < BOOT + 20; i++) next_cycle();
        #3; chk_out("sat0", exp_of(32'h44, 0, 0, 0, 0, CNT_MAX));
        next_cycle();
        drive(1,0,0,0,0,0,32'h40);
        #3; chk_out("sat1", exp_of(32'h44, 1, 1, 0, 0, CNT_MAX));
        next_cycle();

        // Randomized run against the reference model.
        do_reset("rst3");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset($sformatf("rr%0d", i));
                continue;
            end
            imem_ready_i    = ($urandom_range(3) != 0);
            stall_req_i     = ($urandom_range(4) == 0);
            branch_taken_i  = ($urandom_range(6) == 0);
            jump_i          = ($urandom_range(6) == 0);
            branch_target_i = $urandom();
            jump_target_i   = $urandom();
            pc_out_i        = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom();
            #3;
            e = model_eval();
            chk_out($sformatf("rnd%0d", i), e);
            model_step(e);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
